// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit stages.
//   rx_state_t      receiver FSM states
//   OVS             oversample ticks per bit
//   SAMPLE_LO/MID/HI tick indices voted on within each bit
//   DATA_BITS       data bits per frame
//   maj3()          two-out-of-three majority
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int OVS        = 16;
    localparam int TICK_W     = $clog2(OVS);
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, one tick every DIV clocks.
//   clk    in  system clock
//   reset  in  synchronous, active-low
//   clear  in  restart the divider; the first tick follows DIV clocks later
//   tick   out one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (clear || (div_q == '0)) begin
            div_d = RELOAD;
        end else begin
            div_d = div_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= RELOAD;
        end else begin
            div_q <= div_d;
        end
    end

    // A clear cycle never emits a tick, so the count restarts cleanly.
    assign tick = (div_q == '0) && !clear;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver (16x oversampling, majority vote, stop check)
// feeding the load/store unit.
//   clk         in      system clock
//   reset       in      synchronous, active-low
//   rx_serial   in      asynchronous serial line, idles high
//   rx_data     out [8] last correctly framed byte, LSB received first
//   rx_do       out     one-cycle strobe: rx_data holds a new byte
//   frame_err   out     one-cycle strobe: stop bit sampled low
//   parity_err  out     one-cycle strobe: even-parity mismatch
//   busy        out     high from start detection until back in IDLE
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit between
// the data and stop bits; without it the frame is 8N1 and parity_err is 0.
//
// state  | meaning
// IDLE   | line idle, waiting for a synced 1->0 edge
// START  | start bit; a high vote is a glitch and returns to IDLE
// DATA   | shifting 8 voted data bits, LSB first
// PARITY | voting the parity bit (UART_RX_PARITY_EN only)
// STOP   | stop bit, decided at the tick-9 vote
// BREAK  | stop bit was low; wait for the line to go high
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_do,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

    localparam logic [TICK_W-1:0] T_LO  = TICK_W'(SAMPLE_LO);
    localparam logic [TICK_W-1:0] T_MID = TICK_W'(SAMPLE_MID);
    localparam logic [TICK_W-1:0] T_HI  = TICK_W'(SAMPLE_HI);
    localparam logic [TICK_W-1:0] T_END = TICK_W'(OVS - 1);
    localparam logic [2:0]        B_END = 3'(DATA_BITS - 1);

    rx_state_t         state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              s_lo_q, s_lo_d;
    logic              s_mid_q, s_mid_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_do_q, rx_do_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic fall;
    logic tick;
    logic baud_clear;
    logic vote;
    logic at_lo, at_mid, at_hi, at_end;

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    // sync_q[1] is the only view of the line used for any decision.
    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    assign at_lo  = tick && (tick_cnt_q == T_LO);
    assign at_mid = tick && (tick_cnt_q == T_MID);
    assign at_hi  = tick && (tick_cnt_q == T_HI);
    assign at_end = tick && (tick_cnt_q == T_END);

    // The third sample is taken live at tick 9, so the vote is valid when at_hi.
    assign vote = maj3(s_lo_q, s_mid_q, rx_s);

    always_comb begin
        sync_d      = {sync_q[0], rx_serial};
        prev_d      = rx_s;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        s_lo_d      = s_lo_q;
        s_mid_d     = s_mid_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_do_d     = 1'b0;
        frame_err_d = 1'b0;
        baud_clear  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        if (tick) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (at_lo) begin
            s_lo_d = rx_s;
        end
        if (at_mid) begin
            s_mid_d = rx_s;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                if (fall) begin
                    state_d    = START;
                    baud_clear = 1'b1;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (at_hi && vote) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_hi) begin
                    shreg_d = {vote, shreg_q[7:1]};
                end
                if (at_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == B_END) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                // Even parity: data plus parity bit must hold an even count of ones.
                if (at_hi) begin
                    par_bad_d = ^{shreg_q, vote};
                end
                if (at_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at tick 9 instead of the bit end leaves slack for a
                // sender running slightly fast on back-to-back frames.
                if (at_hi) begin
                    if (vote) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_do_d   = 1'b1;
                            rx_data_d = shreg_q;
                        end
`else
                        rx_do_d   = 1'b1;
                        rx_data_d = shreg_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Only a high line re-arms IDLE, so a held-low break cannot
                // look like a new start edge.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            s_lo_q      <= 1'b1;
            s_mid_q     <= 1'b1;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_do_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            s_lo_q      <= s_lo_d;
            s_mid_q     <= s_mid_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_do_q     <= rx_do_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_do     = rx_do_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int BIT_CLKS    = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS  = 11;
`else
    localparam int FRAME_BITS  = 10;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_do;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_byte #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .rx_data    (rx_data),
        .rx_do      (rx_do),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Monitor: records what the DUT emits; all judging happens in the main sequence.
    int   n_do = 0, n_fe = 0, n_pe = 0;
    int   n_wide = 0, n_overlap = 0, n_unstable = 0;
    int   busy_rise_cyc = 0, do_cyc = 0;
    logic do_prev = 1'b0, fe_prev = 1'b0, pe_prev = 1'b0, busy_prev = 1'b0;
    logic rst_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (rx_do) begin
            n_do++;
            obs_q.push_back(rx_data);
            do_cyc = cyc;
        end
        if (frame_err) n_fe++;
        if (parity_err) n_pe++;
        if ((rx_do && do_prev) || (frame_err && fe_prev) || (parity_err && pe_prev)) n_wide++;
        if ((int'(rx_do) + int'(frame_err) + int'(parity_err)) > 1) n_overlap++;
        if (rst_prev && !rx_do && (rx_data !== data_prev)) n_unstable++;
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        do_prev   = rx_do;
        fe_prev   = frame_err;
        pe_prev   = parity_err;
        busy_prev = busy;
        rst_prev  = reset;
        data_prev = rx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic chk_range(input string tag, input int obs_v, input int lo, input int hi);
        n_cmp++;
        assert (obs_v >= lo && obs_v <= hi) else begin
            n_mis++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs_v, lo, hi);
        end
    endtask

    // Pop expected bytes against the bytes the monitor saw, then require both queues empty.
    task automatic drain(input string tag);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e;
            logic [7:0] o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_data"}, 32'(o), 32'(e));
        end
        chk({tag, "_missing"}, exp_q.size(), 0);
        chk({tag, "_unexpected"}, obs_q.size(), 0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_serial = bits[i];
            clocks(BIT_CLKS);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^d;
        f[10]  = stop;
`else
        f[9]   = stop;
`endif
        send_bits(f, FRAME_BITS);
    endtask

    initial begin
        int fe0;
        logic [11:0] f55;

        // Reset state
        reset     = 1'b0;
        rx_serial = 1'b1;
        clocks(3);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_do", 32'(rx_do), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        clocks(20);

        // 1: single byte, latency from start detection to rx_do
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        clocks(20);
        drain("t1");
        chk_range("t1_latency", do_cyc - busy_rise_cyc, 151, 155);
        chk("t1_frame_err", n_fe, 0);
        chk("t1_busy_idle", 32'(busy), 0);

        // 2: back-to-back LOAD reply bytes
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        clocks(20);
        drain("t2");
        chk("t2_rx_data_last", 32'(rx_data), 32'h34);

        // 3: 4-clk glitch is rejected, then a real byte
        rx_serial = 1'b0;
        clocks(4);
        rx_serial = 1'b1;
        clocks(30);
        chk("t3_busy_after_glitch", 32'(busy), 0);
        drain("t3_glitch");
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        clocks(20);
        drain("t3");

        // 4: stop bit low, line held low, then released
        fe0 = n_fe;
        send_byte(8'hFF, 1'b0);
        clocks(40);
        chk("t4_frame_err_count", n_fe - fe0, 1);
        chk("t4_busy_while_low", 32'(busy), 1);
        chk("t4_rx_data_kept", 32'(rx_data), 32'h3C);
        rx_serial = 1'b1;
        clocks(20);
        chk("t4_busy_released", 32'(busy), 0);
        chk("t4_frame_err_no_retrigger", n_fe - fe0, 1);
        drain("t4");

        // 5: reset in data bit 4 of 8'h55; the sender aborts with the line high,
        // since a receiver cannot tell an aborted frame's tail from a new start.
        f55      = '1;
        f55[0]   = 1'b0;
        f55[8:1] = 8'h55;
        send_bits(f55, 5);
        rx_serial = f55[5];
        clocks(8);
        reset = 1'b0;
        clocks(1);
        reset = 1'b1;
        chk("t5_rst_rx_data", 32'(rx_data), 32'h00);
        chk("t5_rst_rx_do", 32'(rx_do), 0);
        chk("t5_rst_frame_err", 32'(frame_err), 0);
        chk("t5_rst_parity_err", 32'(parity_err), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        rx_serial = 1'b1;
        clocks(40);
        drain("t5_abort");
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        clocks(20);
        drain("t5");

`ifdef UART_RX_PARITY_EN
        // 6: wrong then right parity for 8'h07 (three ones, even parity bit = 1)
        begin
            logic [11:0] f07;
            f07      = '1;
            f07[0]   = 1'b0;
            f07[8:1] = 8'h07;
            f07[9]   = 1'b0;
            f07[10]  = 1'b1;
            send_bits(f07, FRAME_BITS);
            clocks(20);
            chk("t6_parity_err_count", n_pe, 1);
            chk("t6_rx_data_kept", 32'(rx_data), 32'h81);
            drain("t6_bad");
            exp_q.push_back(8'h07);
            f07[9] = 1'b1;
            send_bits(f07, FRAME_BITS);
            clocks(20);
            drain("t6_good");
            chk("t6_parity_err_total", n_pe, 1);
        end
`else
        chk("parity_err_never", n_pe, 0);
`endif

        chk("strobe_width", n_wide, 0);
        chk("strobe_exclusive", n_overlap, 0);
        chk("rx_data_stable", n_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
